// File: rtl/load_store_unit_pkg.sv
// Shared width codes, FSM state encoding and access-legality helper for the load/store unit.
package load_store_unit_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_WAIT_R = 2'b10,
    ST_DONE   = 2'b11
  } lsu_state_e;

  // Stores only know B/H/W; loads additionally accept the unsigned B/H forms.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) begin
      bad = (f3 > F3_SW);
    end else begin
      bad = !((f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
              (f3 == F3_LBU) || (f3 == F3_LHU));
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, replicated store data, load extraction and access checks.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic                is_store,
  input  logic [1:0]          addr_lo,
  input  logic [LSU_XLEN-1:0] store_data,
  input  logic [LSU_XLEN-1:0] rdata,
  output logic [3:0]          be,
  output logic [LSU_XLEN-1:0] wdata,
  output logic [LSU_XLEN-1:0] load_data,
  output logic                misaligned,
  output logic                illegal
);

  logic [2:0]          size_s;
  logic [LSU_XLEN-1:0] shifted_s;

  assign size_s    = {1'b0, funct3[1:0]};
  assign shifted_s = rdata >> {addr_lo, 3'b000};

  // Request side: lane enables, replicated write data and error flags.
  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    misaligned = 1'b0;
    illegal    = f3_illegal(is_store, funct3);
    case (size_s)
      F3_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_SW: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        be         = 4'b0000;
        wdata      = store_data;
        misaligned = 1'b0;
      end
    endcase
  end

  // Response side: the addressed lane is already at bit 0, only extension remains.
  always_comb begin
    load_data = shifted_s;
    case (funct3)
      F3_LB:   load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LBU:  load_data = {24'h000000, shifted_s[7:0]};
      F3_LH:   load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LHU:  load_data = {16'h0000, shifted_s[15:0]};
      F3_LW:   load_data = shifted_s;
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one access, runs the req/gnt/rvalid handshake, returns extended loads.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [4:0]        rd_i,
  output logic              done_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic [4:0]        load_rd_o,
  output logic              load_we_o,
  output logic              misaligned_o,
  output logic              illegal_o,
  output logic              busy_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i
);

  lsu_state_e  state_r, state_nxt_s;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [4:0]  rd_r;
  logic        is_store_r;

  logic [2:0]      sel_f3_s;
  logic [1:0]      sel_addr_lo_s;
  logic            sel_store_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] load_data_s;
  logic            misaligned_s;
  logic            illegal_s;
  logic            accept_s;
  logic            go_s;

  // In IDLE the aligner checks the incoming request; afterwards it decodes the captured access.
  assign sel_f3_s      = (state_r == ST_IDLE) ? funct3_i    : funct3_r;
  assign sel_addr_lo_s = (state_r == ST_IDLE) ? addr_i[1:0] : addr_lo_r;
  assign sel_store_s   = (state_r == ST_IDLE) ? is_store_i  : is_store_r;

  lsu_align u_align (
    .funct3     (sel_f3_s),
    .is_store   (sel_store_s),
    .addr_lo    (sel_addr_lo_s),
    .store_data (store_data_i),
    .rdata      (dmem_rdata_i),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s),
    .misaligned (misaligned_s),
    .illegal    (illegal_s)
  );

  assign accept_s = (state_r == ST_IDLE) && req_valid_i && (is_load_i ^ is_store_i);
  assign go_s     = accept_s && !illegal_s && !misaligned_s;

  // Next-state logic for the handshake sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s) state_nxt_s = ST_REQ;
        else      state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (!dmem_gnt_i)                     state_nxt_s = ST_REQ;
        else if (is_store_r || dmem_rvalid_i) state_nxt_s = ST_DONE;
        else                                  state_nxt_s = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (dmem_rvalid_i) state_nxt_s = ST_DONE;
        else               state_nxt_s = ST_WAIT_R;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, capture registers and registered outputs, all derived from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      funct3_r     <= 3'b000;
      addr_lo_r    <= 2'b00;
      rd_r         <= 5'd0;
      is_store_r   <= 1'b0;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      load_we_o    <= 1'b0;
      load_data_o  <= '0;
      load_rd_o    <= 5'd0;
      misaligned_o <= 1'b0;
      illegal_o    <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= 4'b0000;
      dmem_wdata_o <= '0;
    end else begin
      state_r      <= state_nxt_s;
      req_ready_o  <= (state_nxt_s == ST_IDLE);
      busy_o       <= (state_nxt_s != ST_IDLE);
      done_o       <= (state_nxt_s == ST_DONE);
      load_we_o    <= (state_nxt_s == ST_DONE) && !is_store_r;
      illegal_o    <= accept_s && illegal_s;
      misaligned_o <= accept_s && !illegal_s && misaligned_s;
      dmem_req_o   <= (state_nxt_s == ST_REQ);
      dmem_we_o    <= (state_nxt_s == ST_REQ) && sel_store_s;
      if (go_s) begin
        funct3_r     <= funct3_i;
        addr_lo_r    <= addr_i[1:0];
        rd_r         <= rd_i;
        is_store_r   <= is_store_i;
        dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
        dmem_be_o    <= be_s;
        dmem_wdata_o <= wdata_s;
      end
      // Read data is captured on the way into DONE so it holds afterwards.
      if ((state_r != ST_IDLE) && (state_r != ST_DONE) &&
          (state_nxt_s == ST_DONE) && !is_store_r) begin
        load_data_o <= load_data_s;
        load_rd_o   <= rd_r;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table for single accesses plus wait-state and reset sequences.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        done_o;
  logic [31:0] load_data_o;
  logic [4:0]  load_rd_o;
  logic        load_we_o;
  logic        misaligned_o;
  logic        illegal_o;
  logic        busy_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .rd_i(rd_i), .done_o(done_o), .load_data_o(load_data_o),
    .load_rd_o(load_rd_o), .load_we_o(load_we_o), .misaligned_o(misaligned_o),
    .illegal_o(illegal_o), .busy_o(busy_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  localparam logic [1:0] K_OK  = 2'd0;
  localparam logic [1:0] K_MIS = 2'd1;
  localparam logic [1:0] K_ILL = 2'd2;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [1:0]  kind;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid_i   = 1'b0;
    is_load_i     = 1'b0;
    is_store_i    = 1'b0;
    funct3_i      = 3'b000;
    addr_i        = 32'h0;
    store_data_i  = 32'h0;
    rd_i          = 5'd0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    req_valid_i  = 1'b1;
    is_load_i    = ld;
    is_store_i   = st;
    funct3_i     = f3;
    addr_i       = addr;
    store_data_i = sd;
    rd_i         = rd;
  endtask

  // One access with a zero-wait memory; all checks are made on the falling edge.
  task automatic apply_vec(input vec_t v);
    @(negedge clk_i);
    present(v.ld, v.st, v.f3, v.addr, v.sdata, 5'd7);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    if (v.kind != K_OK) begin
      check("misaligned_pulse", {31'd0, misaligned_o}, {31'd0, v.kind == K_MIS});
      check("illegal_pulse", {31'd0, illegal_o}, {31'd0, v.kind == K_ILL});
      check("err_no_req", {31'd0, dmem_req_o}, 32'd0);
      check("err_ready", {31'd0, req_ready_o}, 32'd1);
      @(negedge clk_i);
      check("err_pulse_end", {30'd0, misaligned_o, illegal_o}, 32'd0);
      check("err_still_no_req", {31'd0, dmem_req_o}, 32'd0);
    end else begin
      check("req", {31'd0, dmem_req_o}, 32'd1);
      check("addr", dmem_addr_o, {v.addr[31:2], 2'b00});
      check("be", {28'd0, dmem_be_o}, {28'd0, v.be});
      check("we", {31'd0, dmem_we_o}, {31'd0, v.st});
      check("busy", {30'd0, busy_o, req_ready_o}, 32'd2);
      if (v.st) check("wdata", dmem_wdata_o, v.wdata);
      dmem_gnt_i    = 1'b1;
      dmem_rvalid_i = v.ld;
      dmem_rdata_i  = v.rdata;
      @(negedge clk_i);
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      check("done", {30'd0, done_o, req_ready_o}, 32'd2);
      check("load_we", {31'd0, load_we_o}, {31'd0, v.ld});
      check("req_dropped", {31'd0, dmem_req_o}, 32'd0);
      if (v.ld) begin
        check("load_data", load_data_o, v.ldata);
        check("load_rd", {27'd0, load_rd_o}, 32'd7);
      end
      @(negedge clk_i);
      check("back_idle", {29'd0, done_o, load_we_o, req_ready_o}, 32'd1);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0, K_OK, 4'b1000, 32'hABAB_ABAB, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h12F4_5678, K_OK, 4'b0100, 32'h0, 32'hFFFF_FFF4};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h12F4_5678, K_OK, 4'b0100, 32'h0, 32'h0000_00F4};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h12F4_5678, K_OK, 4'b1100, 32'h0, 32'h0000_12F4};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8678, K_OK, 4'b0011, 32'h0, 32'hFFFF_8678};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_8678, K_OK, 4'b0011, 32'h0, 32'h0000_8678};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, K_OK, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h1234_5678, 32'h0, K_OK, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_000C, 32'h0, 32'hCAFE_F00D, K_OK, 4'b1111, 32'h0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_8000, K_OK, 4'b0010, 32'h0, 32'hFFFF_FF80};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, K_MIS, 4'b0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0, 32'h0, K_MIS, 4'b0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0, 32'h0, K_ILL, 4'b0, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b110, 32'h0000_0100, 32'h0, 32'h0, K_ILL, 4'b0, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 3'b100, 32'h0000_0101, 32'h0, 32'h0, K_ILL, 4'b0, 32'h0, 32'h0};

    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_outs", {24'd0, done_o, load_we_o, misaligned_o, illegal_o, busy_o,
                       dmem_req_o, dmem_we_o, 1'b0}, 32'd0);
    check("rst_bus", dmem_addr_o | dmem_wdata_o | {28'd0, dmem_be_o} | load_data_o, 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 15; i++) apply_vec(vecs[i]);

    // Both and neither access type: nothing happens.
    @(negedge clk_i);
    present(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
    @(negedge clk_i);
    check("both_no_req", {29'd0, dmem_req_o, busy_o, req_ready_o}, 32'd1);
    present(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
    @(negedge clk_i);
    check("neither_no_req", {29'd0, dmem_req_o, busy_o, req_ready_o}, 32'd1);
    req_valid_i = 1'b0;

    // SW with grant held off for three cycles.
    @(negedge clk_i);
    present(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 5'd0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("sw_hold_req", {28'd0, dmem_req_o, dmem_we_o, busy_o, req_ready_o}, 32'hE);
      check("sw_hold_addr", dmem_addr_o, 32'h0000_0200);
      check("sw_hold_be", {28'd0, dmem_be_o}, 32'hF);
      check("sw_hold_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
      check("sw_no_done", {31'd0, done_o}, 32'd0);
      if (c == 3) dmem_gnt_i = 1'b1;
      @(negedge clk_i);
    end
    dmem_gnt_i = 1'b0;
    check("sw_done", {29'd0, done_o, load_we_o, dmem_req_o}, 32'd4);
    @(negedge clk_i);
    check("sw_idle", {30'd0, done_o, req_ready_o}, 32'd1);

    // LW rd=5: grant, then read data two cycles later.
    present(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd5);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    dmem_gnt_i  = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check("lw_wait_no_req", {30'd0, dmem_req_o, busy_o}, 32'd1);
    @(negedge clk_i);
    check("lw_wait2", {30'd0, done_o, busy_o}, 32'd1);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h8000_0001;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("lw_done", {30'd0, done_o, load_we_o}, 32'd3);
    check("lw_data", load_data_o, 32'h8000_0001);
    check("lw_rd", {27'd0, load_rd_o}, 32'd5);
    @(negedge clk_i);
    check("lw_we_one_cycle", {30'd0, load_we_o, done_o}, 32'd0);
    check("lw_data_held", load_data_o, 32'h8000_0001);
    check("lw_rd_held", {27'd0, load_rd_o}, 32'd5);

    // Reset while waiting for read data; the late rvalid must be ignored.
    present(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd9);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    dmem_gnt_i  = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    rst_ni     = 1'b0;
    @(negedge clk_i);
    rst_ni        = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5555_AAAA;
    check("rst_mid_idle", {30'd0, busy_o, req_ready_o}, 32'd1);
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("late_rvalid_ignored", {28'd0, done_o, load_we_o, busy_o, req_ready_o}, 32'd1);
    check("late_rvalid_data", load_data_o, 32'h0);
    apply_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage responder to the decoder's `is_load`/`is_store` outputs.
- Accepts one load or store per transaction from the execute/memory pipeline.
- Drives a request/grant/rvalid data-memory port.
- Generates byte enables and replicated store data; aligns and sign/zero-extends load data.
- Flags misaligned and illegal-width accesses without touching memory.
- Holds the pipeline via `req_ready_o`/`busy_o` while an access is outstanding.

Parameters:
- XLEN, 32, data width (only 32 supported).
- ADDR_W, 32, address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  pipeline presents an access.
- req_ready_o  out  1  unit accepts an access this cycle.
- is_load_i  in  1  access is a load.
- is_store_i  in  1  access is a store.
- funct3_i  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  ADDR_W  byte address.
- store_data_i  in  XLEN  rs2 value.
- rd_i  in  5  load destination register.
- done_o  out  1  one-cycle pulse: access completed.
- load_data_o  out  XLEN  extended load result; valid when done_o and load.
- load_rd_o  out  5  rd of completed load.
- load_we_o  out  1  done_o and access was a load.
- misaligned_o  out  1  one-cycle pulse: misaligned access rejected.
- illegal_o  out  1  one-cycle pulse: illegal funct3 rejected.
- busy_o  out  1  state != IDLE.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  write.
- dmem_addr_o  out  ADDR_W  word-aligned address (`addr[1:0]` = 00).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  XLEN  write data.
- dmem_gnt_i  in  1  memory accepted the request.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  read data.

Behaviour:
- Reset (`rst_ni`=0 at a rising edge): state IDLE. All outputs 0 except `req_ready_o`=1. Captured request registers cleared.
- Reset mid-transaction: return to IDLE and drop the outstanding access. A late `dmem_rvalid_i` arriving in IDLE is ignored.
- Accept condition: IDLE && `req_valid_i` && (`is_load_i` ^ `is_store_i`). `req_ready_o` = (state==IDLE).
- IDLE with both or neither of `is_load_i`/`is_store_i`: no action.
- Checks on accept, evaluated in order:
  - Illegal: load funct3 in {011, 110, 111}, or store funct3 >= 011. Pulse `illegal_o` next cycle, stay IDLE.
  - Misaligned: H/HU with `addr[0]`=1, or W with `addr[1:0]`!=0. Pulse `misaligned_o` next cycle, stay IDLE.
  - Neither error: register addr, be, wdata, funct3, rd, load/store and enter REQ.
- Store byte enables and write data:
  - SB: be = 0001 << `addr[1:0]`; wdata = byte replicated 4x.
  - SH: be = 0011 << (2*`addr[1]`); wdata = halfword replicated 2x.
  - SW: be = 1111; wdata = store data unchanged.
- Loads: same be pattern as the matching store width; `dmem_we_o`=0.
- REQ state:
  - `dmem_req_o`=1 with addr/we/be/wdata held stable until `dmem_gnt_i`.
  - Store + gnt: go to DONE.
  - Load + gnt without rvalid: go to WAIT_R.
  - Load + gnt + rvalid in the same cycle (zero-wait memory): capture data, go to DONE.
- WAIT_R state: `dmem_req_o`=0. On `dmem_rvalid_i`, capture `dmem_rdata_i` and go to DONE.
- DONE state: one cycle, then IDLE.
  - `done_o`=1.
  - `load_we_o`=1 for loads; `load_rd_o` = captured rd.
  - `load_data_o`: shift rdata right by 8*`addr[1:0]`, then extend:
    - B: sign-extend bits [7:0].
    - BU: zero-extend bits [7:0].
    - H: sign-extend bits [15:0].
    - HU: zero-extend bits [15:0].
    - W: bits [31:0] unchanged.
  - `req_ready_o`=0 in DONE, so the next access is accepted in the following IDLE cycle.
- Latency:
  - Store, 0-wait gnt: accept -> REQ -> DONE = 2 cycles to `done_o`.
  - Load, gnt+rvalid same cycle: same 2 cycles.
  - Each extra gnt or rvalid wait adds 1 cycle.
- `load_data_o` and `load_rd_o` hold their last values outside DONE. `load_we_o` is 0 outside DONE.

Decomposition:
- Shared constants go in `encodings.vh`:
  - LSU width codes: LB/LH/LW/LBU/LHU and SB/SH/SW funct3 values.
  - FSM state encodings: IDLE/REQ/WAIT_R/DONE.
- One combinational sub-module, `lsu_align`:
  - Inputs: funct3, `addr[1:0]`, store data, read data.
  - Outputs: be, replicated wdata, extended load data, misaligned flag, illegal flag.
- The top level holds the FSM and capture registers.

Test Plan:
1. SB, addr 0x00000103, store_data 0x000000AB, gnt immediate -> `dmem_addr_o`=0x00000100, be=1000, wdata=0xABABABAB, we=1; `done_o` 2 cycles after accept; `load_we_o`=0.
2. LB at 0x00000102, rdata 0x12F45678 with gnt+rvalid in the same cycle -> `load_data_o`=0xFFFFFFF4. LBU with the same stimulus -> 0x000000F4. LH at 0x00000102 -> 0x000012F4.
3. LH at 0x00000101 -> `misaligned_o` pulses next cycle; `dmem_req_o` never asserts; `req_ready_o` stays 1. Store with funct3=011 -> `illegal_o` pulse, no request.
4. SW at 0x00000200, data 0xDEADBEEF, gnt delayed 3 cycles -> `dmem_req_o`/addr/be=1111/wdata stable for 4 cycles; `req_ready_o`=0 and `busy_o`=1 throughout; `done_o` on the cycle after gnt.
5. LW at 0x00000010 with rd=5: gnt, then rvalid 2 cycles later carrying 0x80000001 -> `load_data_o`=0x80000001, `load_rd_o`=5, `load_we_o`=1 for exactly 1 cycle.
6. LW in WAIT_R, assert `rst_ni`=0 for 1 cycle, then rvalid arrives -> unit is IDLE, `done_o` stays 0, `req_ready_o`=1, next SB is accepted normally.
